// File: rtl/mux16_rr_scheduler_pkg.sv
// rtl/mux16_rr_scheduler_pkg.sv - shared constants, state type and helpers for the 16-way round-robin scheduler
package mux16_rr_scheduler_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot grant vector for a requester index
    function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux16_rr_scheduler_rr_pick16.sv
// rtl/mux16_rr_scheduler_rr_pick16.sv - combinational circular priority encoder starting at ptr
module rr_pick16
    import mux16_rr_scheduler_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Scan ptr, ptr+1, ... with 4-bit wraparound; first set bit wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[ptr + SEL_W'(i)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// rtl/mux16_rr_scheduler.sv - round-robin burst scheduler driving a shared 16:1 bit mux
module mux16_rr_scheduler
    import mux16_rr_scheduler_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             mux_out,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic             data_q,
    output logic             data_valid
);

    generate
        if (BURST < 1 || BURST > 15) begin : g_bad_burst
            $error("mux16_rr_scheduler: BURST must be in 1..15");
        end
    endgenerate

    localparam logic [SEL_W-1:0] BURST_C = SEL_W'(BURST);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] cnt;
    logic [SEL_W-1:0] search_base;
    logic [SEL_W-1:0] win;
    logic             found;
    logic             hold;

    // While a grant is held, any re-arbitration starts just past the holder,
    // which is exactly where ptr lands on release, so no bubble is needed.
    assign search_base = (state == ST_GRANT) ? sel + 4'd1 : ptr;
    assign hold        = req[sel] && en && (cnt < BURST_C);

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (search_base),
        .found (found),
        .idx   (win)
    );

    // Arbitration FSM: grant, hold for up to BURST cycles, release and re-arbitrate
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en && found) begin
                        state     <= ST_GRANT;
                        gnt       <= onehot16(win);
                        sel       <= win;
                        gnt_valid <= 1'b1;
                        cnt       <= 4'd1;
                    end
                end
                ST_GRANT: begin
                    if (hold) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        ptr <= sel + 4'd1;
                        if (en && found) begin
                            gnt <= onehot16(win);
                            sel <= win;
                            cnt <= 4'd1;
                        end else begin
                            state     <= ST_IDLE;
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            cnt       <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture the mux bit for the current holder; data_valid trails gnt_valid by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            if (gnt_valid) begin
                data_q <= mux_out;
            end
            data_valid <= gnt_valid;
        end
    end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// tb/tb_mux16_rr_scheduler.sv - directed self-checking bench for mux16_rr_scheduler
module tb_mux16_rr_scheduler;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        mux_out;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic        data_q;
    logic        data_valid;

    logic [15:0] img;
    int          errors;
    int          checks;

    mux16_rr_scheduler #(.BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .mux_out    (mux_out),
        .sel        (sel),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid),
        .data_q     (data_q),
        .data_valid (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16:1 mux tree model driven by the scheduler's select
    always_comb mux_out = img[sel];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = 16'h0000;
        en  = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 16'hFFFF;
        en  = 1'b1;
        step();
        step();
        checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL reset_gnt: got %h expected %h", gnt, 16'h0000); end
        checks++; if (sel !== 4'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid: got %b expected 0", gnt_valid); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        checks++; if (data_q !== 1'b0) begin errors++; $display("FAIL reset_data_q: got %b expected 0", data_q); end
        rst = 1'b0;
        req = 16'h0000;
    endtask

    task automatic test_en_low_idle();
        apply_reset();
        en  = 1'b0;
        req = 16'hFFFF;
        step();
        step();
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL en_low_idle_gnt_valid: got %b expected 0", gnt_valid); end
        checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL en_low_idle_gnt: got %h expected 0000", gnt); end
        en = 1'b1;
    endtask

    task automatic test_sole_requester();
        logic [3:0] exp_cnt;
        apply_reset();
        req = 16'h0020;
        for (int c = 0; c < 10; c++) begin
            step();
            exp_cnt = 4'((c % 4) + 1);
            checks++; if (gnt !== 16'h0020) begin errors++; $display("FAIL sole_gnt[%0d]: got %h expected 0020", c, gnt); end
            checks++; if (sel !== 4'd5) begin errors++; $display("FAIL sole_sel[%0d]: got %0d expected 5", c, sel); end
            checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL sole_gnt_valid[%0d]: got %b expected 1", c, gnt_valid); end
            checks++; if (dut.cnt !== exp_cnt) begin errors++; $display("FAIL sole_cnt[%0d]: got %0d expected %0d", c, dut.cnt, exp_cnt); end
        end
        req = 16'h0000;
        step();
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL sole_release_gnt_valid: got %b expected 0", gnt_valid); end
        checks++; if (sel !== 4'd5) begin errors++; $display("FAIL sole_release_sel_holds: got %0d expected 5", sel); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_sel;
        logic [15:0] exp_gnt;
        apply_reset();
        req = 16'h8001;
        for (int c = 0; c < 12; c++) begin
            step();
            exp_sel = (c >= 4 && c < 8) ? 4'd15 : 4'd0;
            exp_gnt = (c >= 4 && c < 8) ? 16'h8000 : 16'h0001;
            checks++; if (sel !== exp_sel) begin errors++; $display("FAIL b2b_sel[%0d]: got %0d expected %0d", c, sel, exp_sel); end
            checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL b2b_gnt[%0d]: got %h expected %h", c, gnt, exp_gnt); end
            checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL b2b_gnt_valid[%0d]: got %b expected 1", c, gnt_valid); end
        end
    endtask

    task automatic test_early_release();
        apply_reset();
        req = 16'h0208;
        step();
        checks++; if (sel !== 4'd3) begin errors++; $display("FAIL early_first_sel: got %0d expected 3", sel); end
        step();
        checks++; if (dut.cnt !== 4'd2) begin errors++; $display("FAIL early_hold_cnt: got %0d expected 2", dut.cnt); end
        req = 16'h0200;
        step();
        checks++; if (sel !== 4'd9) begin errors++; $display("FAIL early_sel: got %0d expected 9", sel); end
        checks++; if (gnt !== 16'h0200) begin errors++; $display("FAIL early_gnt: got %h expected 0200", gnt); end
        checks++; if (dut.cnt !== 4'd1) begin errors++; $display("FAIL early_cnt: got %0d expected 1", dut.cnt); end
        checks++; if (dut.ptr !== 4'd4) begin errors++; $display("FAIL early_ptr: got %0d expected 4", dut.ptr); end
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL early_gnt_valid: got %b expected 1", gnt_valid); end
    endtask

    task automatic test_data_path();
        logic [3:0] exp_sel;
        logic       exp_dq;
        logic       exp_dv;
        int         k;
        apply_reset();
        img = 16'hA5C3;
        req = 16'hFFFF;
        for (k = 0; k < 12; k++) begin
            step();
            exp_sel = 4'(k / 4);
            exp_dv  = (k >= 1);
            exp_dq  = (k == 0) ? 1'b0 : img[4'((k - 1) / 4)];
            checks++; if (sel !== exp_sel) begin errors++; $display("FAIL data_sel[%0d]: got %0d expected %0d", k, sel, exp_sel); end
            checks++; if (data_valid !== exp_dv) begin errors++; $display("FAIL data_valid[%0d]: got %b expected %b", k, data_valid, exp_dv); end
            checks++; if (data_q !== exp_dq) begin errors++; $display("FAIL data_q[%0d]: got %b expected %b", k, data_q, exp_dq); end
        end
    endtask

    task automatic test_mid_burst_disable_and_reset();
        apply_reset();
        req = 16'h0030;
        step();
        checks++; if (sel !== 4'd4) begin errors++; $display("FAIL midburst_first_sel: got %0d expected 4", sel); end
        step();
        en = 1'b0;
        step();
        checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL midburst_en0_gnt: got %h expected 0000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL midburst_en0_gnt_valid: got %b expected 0", gnt_valid); end
        checks++; if (dut.ptr !== 4'd5) begin errors++; $display("FAIL midburst_en0_ptr: got %0d expected 5", dut.ptr); end
        checks++; if (sel !== 4'd4) begin errors++; $display("FAIL midburst_en0_sel_holds: got %0d expected 4", sel); end
        en = 1'b1;
        step();
        checks++; if (sel !== 4'd5) begin errors++; $display("FAIL midburst_resume_sel: got %0d expected 5", sel); end
        checks++; if (gnt !== 16'h0020) begin errors++; $display("FAIL midburst_resume_gnt: got %h expected 0020", gnt); end
        step();
        rst = 1'b1;
        step();
        checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL midburst_rst_gnt: got %h expected 0000", gnt); end
        checks++; if (sel !== 4'd0) begin errors++; $display("FAIL midburst_rst_sel: got %0d expected 0", sel); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL midburst_rst_gnt_valid: got %b expected 0", gnt_valid); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL midburst_rst_data_valid: got %b expected 0", data_valid); end
        checks++; if (data_q !== 1'b0) begin errors++; $display("FAIL midburst_rst_data_q: got %b expected 0", data_q); end
        checks++; if (dut.ptr !== 4'd0) begin errors++; $display("FAIL midburst_rst_ptr: got %0d expected 0", dut.ptr); end
        checks++; if (dut.cnt !== 4'd0) begin errors++; $display("FAIL midburst_rst_cnt: got %0d expected 0", dut.cnt); end
        rst = 1'b0;
        req = 16'h0000;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        img    = 16'hA5C3;
        rst    = 1'b1;
        en     = 1'b1;
        req    = 16'h0000;
        test_reset();
        test_en_low_idle();
        test_sole_requester();
        test_back_to_back();
        test_early_release();
        test_data_path();
        test_mid_burst_disable_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
